irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Memory-mapped interrupt controller between the peripheral interrupt sources (timer, UART) and the single-cycle core's Interrupt input.
- Latches source edges into a pending register and applies a mask.
- Selects one source by fixed priority and drives a single request to the core.
- Sequences the request/service/end-of-interrupt handshake using the core's kernel-mode flag (PC[31]).

Parameters:
- NUM_SRC, 2, number of interrupt sources (1..8); bit 0 = timer, bit 1 = UART.
- ID_W, 3, width of the interrupt id field.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- irq_src  input  NUM_SRC  raw interrupt lines from peripherals; rising edge = event.
- kernel_mode  input  1  core PC[31]; 1 = handler/kernel executing.
- addr  input  4  register offset; only addr[3:2] decoded.
- wdata  input  32  write data.
- wr  input  1  register write strobe; single cycle, sampled at posedge.
- rd  input  1  register read strobe.
- rdata  output  32  read data, combinational; 0 when rd=0, so it can be OR-merged onto the load bus.
- irq_out  output  1  interrupt request to the core.
- irq_id  output  ID_W  id of the latched (active) source.

Behaviour:
- Reset (async, reset=1):
  - PEND=0, MASK=0, prev_src=0, active_id=0, state=IDLE.
  - irq_out=0, irq_id=0, rdata=0.
  - prev_src=0 means a line already high at reset release registers as an edge on the first clock.
- Edge detect: edge = irq_src & ~prev_src; prev_src <= irq_src every cycle.
- PEND update, per bit, each cycle: PEND[i] <= edge[i] | (PEND[i] & ~clr[i]).
  - clr[i] = W1C write of PEND bit i, or an EOI write while in SERVICE with active_id==i.
  - A set and a clear on the same bit in the same cycle: set wins.
- Register map (addr[3:2]); unused upper bits read 0:
  - 0: PEND. Read returns PEND. Write is W1C.
  - 1: MASK. Read/write, NUM_SRC bits; 1 = enabled.
  - 2: STATUS. Read-only: {state[1:0] at bits 9:8, active_id at bits ID_W-1:0}.
  - 3: EOI. Write of any data ends service. Reads return 0.
- Request vector: req = PEND & MASK; selection = lowest set index (timer beats UART).
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If req!=0 and kernel_mode=0: latch active_id = selected index, go to REQ.
  - If kernel_mode=1: stay in IDLE (the core is non-reentrant).
- REQ:
  - irq_out=1.
  - If kernel_mode=1: go to SERVICE (the core has vectored to 0x80000004 or 0x80000008).
  - Else if req[active_id]=0 (bit cleared by W1C or masked before acceptance): go to IDLE, withdraw irq_out the next cycle.
  - A higher-priority source arriving while in REQ does not change active_id.
- SERVICE:
  - irq_out=0.
  - An EOI write clears PEND[active_id] and goes to IDLE.
  - The next request can assert only once kernel_mode=0, i.e. after jr $26 back to user space.
  - If kernel_mode drops without EOI: stay in SERVICE; no further requests until EOI.
- EOI written while in IDLE or REQ: ignored, no PEND change.
- irq_out is a registered function of state (1 iff state==REQ); irq_id = active_id.
- Latency:
  - Source edge at cycle n sets PEND at edge n+1.
  - State=REQ and irq_out=1 at edge n+2, provided the source is masked-in and kernel_mode=0.
- A write and a read in the same cycle: rdata shows the pre-write value.
- Sources beyond NUM_SRC: tied off; their PEND/MASK bits read 0, writes ignored.

Test Plan:
- Reset held, then released; MASK=0; pulse irq_src=2'b01 -> PEND reads 0x1, irq_out stays 0, state IDLE.
- MASK=0x3, timer pulse with kernel_mode=0 -> irq_out=1 two clocks after the edge, STATUS=0x100. Raise kernel_mode -> next cycle irq_out=0, STATUS=0x200. EOI write -> PEND=0, STATUS=0x000.
- Timer and UART edges in the same cycle, MASK=0x3 -> active_id=0. After EOI with kernel_mode=0 -> second request with irq_id=1, PEND=0x2.
- In REQ with kernel_mode=0, write PEND=0x1 (W1C) -> returns to IDLE, irq_out=0 next cycle, PEND=0.
- In SERVICE with active_id=0, new timer edge in the same cycle as the EOI write -> PEND[0] remains 1 and a new request follows once kernel_mode=0.
- Assert reset asynchronously while in REQ -> irq_out=0, PEND=0, MASK=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_controller_if.sv
// Register-bus and interrupt-signal bundle between the interrupt controller and its
// environment (peripheral lines, core kernel-mode flag, load/store bus).
interface irq_controller_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ID_W    = 3
);
  logic [NUM_SRC-1:0] irq_src;
  logic               kernel_mode;
  logic [3:0]         addr;
  logic [31:0]        wdata;
  logic               wr;
  logic               rd;
  logic [31:0]        rdata;
  logic               irq_out;
  logic [ID_W-1:0]    irq_id;

  modport master (
    output irq_src, kernel_mode, addr, wdata, wr, rd,
    input  rdata, irq_out, irq_id
  );

  modport slave (
    input  irq_src, kernel_mode, addr, wdata, wr, rd,
    output rdata, irq_out, irq_id
  );
endinterface

// File: rtl/irq_controller.sv
// Edge-latching, fixed-priority interrupt controller with a request/service/EOI handshake
// keyed off the core's kernel-mode flag.
module irq_controller #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ID_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  irq_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } state_e;

  state_e             r_state, w_state_d;
  logic [NUM_SRC-1:0] r_pend, r_mask, r_prev;
  logic [ID_W-1:0]    r_active_id, w_active_id_d;
  logic               r_irq_out;

  logic [NUM_SRC-1:0] w_edge, w_clr, w_req, w_active_oh, w_pend_d;
  logic [ID_W-1:0]    w_sel_id;
  logic               w_wr_pend, w_wr_mask, w_wr_eoi, w_req_active;
  logic [31:0]        w_status;
  logic               w_unused_bits;

  assign w_wr_pend = bus.wr && (bus.addr[3:2] == 2'd0);
  assign w_wr_mask = bus.wr && (bus.addr[3:2] == 2'd1);
  assign w_wr_eoi  = bus.wr && (bus.addr[3:2] == 2'd3);

  assign w_edge = bus.irq_src & ~r_prev;
  assign w_req  = r_pend & r_mask;

  always_comb begin
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      w_active_oh[i] = (r_active_id == ID_W'(i));
    end
  end

  // Lowest index wins: scan downwards so the last hit is the lowest set bit.
  always_comb begin
    w_sel_id = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (w_req[i]) w_sel_id = ID_W'(i);
    end
  end

  assign w_req_active = |(w_req & w_active_oh);

  // EOI only clears the active source when it actually ends a service phase.
  assign w_clr = (w_wr_pend ? bus.wdata[NUM_SRC-1:0] : '0)
               | ((w_wr_eoi && (r_state == StService)) ? w_active_oh : '0);
  assign w_pend_d = w_edge | (r_pend & ~w_clr);

  always_comb begin
    w_state_d     = r_state;
    w_active_id_d = r_active_id;
    unique case (r_state)
      StIdle: begin
        if ((|w_req) && !bus.kernel_mode) begin
          w_state_d     = StReq;
          w_active_id_d = w_sel_id;
        end
      end
      StReq: begin
        if (bus.kernel_mode)    w_state_d = StService;
        else if (!w_req_active) w_state_d = StIdle;
      end
      StService: begin
        if (w_wr_eoi) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_pend      <= '0;
      r_mask      <= '0;
      r_prev      <= '0;
      r_active_id <= '0;
      r_irq_out   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pend      <= w_pend_d;
      r_prev      <= bus.irq_src;
      r_active_id <= w_active_id_d;
      r_irq_out   <= (w_state_d == StReq);
      if (w_wr_mask) r_mask <= bus.wdata[NUM_SRC-1:0];
    end
  end

  always_comb begin
    w_status              = '0;
    w_status[9:8]         = r_state;
    w_status[ID_W-1:0]    = r_active_id;
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      unique case (bus.addr[3:2])
        2'd0:    bus.rdata = 32'(r_pend);
        2'd1:    bus.rdata = 32'(r_mask);
        2'd2:    bus.rdata = w_status;
        default: bus.rdata = '0;
      endcase
    end
  end

  assign bus.irq_out = r_irq_out;
  assign bus.irq_id  = r_active_id;

  assign w_unused_bits = ^{bus.addr[1:0], bus.wdata[31:NUM_SRC]};

endmodule

// File: tb/tb_irq_controller.sv
// Directed plus randomized bench for irq_controller, checked against a cycle-level
// behavioural model of the controller's rules.
module tb_irq_controller;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned SRC_ALL = (1 << NUM_SRC) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irq_controller_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) bus ();

  irq_controller #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0 = idle, 1 = request, 2 = service.
  int unsigned m_pend, m_mask, m_prev, m_state, m_active;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend = 0; m_mask = 0; m_prev = 0; m_state = 0; m_active = 0;
  endfunction

  function automatic int unsigned read_exp(input int unsigned a);
    case (a)
      0:       return m_pend;
      1:       return m_mask;
      2:       return (m_state << 8) | m_active;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs presently on the bus.
  function automatic void model_step();
    int unsigned src, edges, clr, req, a;
    bit eoi;
    src   = 32'(bus.irq_src) & SRC_ALL;
    edges = src & ~m_prev & SRC_ALL;
    a     = 32'(bus.addr) >> 2;
    req   = m_pend & m_mask;
    clr   = 0;
    eoi   = bus.wr && (a == 3);
    if (bus.wr && a == 0) clr = bus.wdata & SRC_ALL;
    if (eoi && m_state == 2) clr = clr | (1 << m_active);
    case (m_state)
      0: if (req != 0 && !bus.kernel_mode) begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
          if ((req >> i) & 1) begin
            m_active = i;
            break;
          end
        end
        m_state = 1;
      end
      1: if (bus.kernel_mode) m_state = 2;
         else if (((req >> m_active) & 1) == 0) m_state = 0;
      default: if (eoi) m_state = 0;
    endcase
    m_pend = edges | (m_pend & ~clr);
    if (bus.wr && a == 1) m_mask = bus.wdata & SRC_ALL;
    m_prev = src;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("irq_out", 32'(bus.irq_out), 32'(m_state == 1));
    check("irq_id", 32'(bus.irq_id), m_active);
  endtask

  task automatic rd_check(input string tag, input int unsigned a);
    bus.addr = 4'(a << 2);
    bus.rd   = 1'b1;
    #1;
    check(tag, bus.rdata, read_exp(a));
    bus.rd = 1'b0;
  endtask

  task automatic do_write(input int unsigned a, input logic [31:0] d);
    bus.addr  = 4'(a << 2);
    bus.wdata = d;
    bus.wr    = 1'b1;
    tick();
    bus.wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.irq_src = '0; bus.kernel_mode = 1'b0; bus.addr = '0;
    bus.wdata = '0; bus.wr = 1'b0; bus.rd = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq_out", 32'(bus.irq_out), 32'd0);
    check("rst_irq_id", 32'(bus.irq_id), 32'd0);
    check("rst_rdata_idle", bus.rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Masked-off pulse only latches.
    bus.irq_src = 2'b01; tick();
    bus.irq_src = 2'b00; tick();
    rd_check("pend_masked", 0);
    check("pend_masked_const", read_exp(0), 32'h1);
    tick();
    rd_check("status_masked", 2);
    do_write(0, 32'h1);

    // Full request / service / EOI.
    do_write(1, 32'h3);
    bus.irq_src = 2'b01; tick();
    bus.irq_src = 2'b00; tick();
    check("req_irq_out", 32'(bus.irq_out), 32'd1);
    rd_check("status_req", 2);
    check("status_req_const", read_exp(2), 32'h100);
    bus.kernel_mode = 1'b1; tick();
    rd_check("status_svc", 2);
    check("status_svc_const", read_exp(2), 32'h200);
    do_write(3, 32'h0);
    rd_check("pend_eoi", 0);
    rd_check("status_eoi", 2);
    bus.kernel_mode = 1'b0; tick();

    // Simultaneous edges: timer first, then UART.
    bus.irq_src = 2'b11; tick();
    bus.irq_src = 2'b00; tick();
    check("prio_id0", 32'(bus.irq_id), 32'd0);
    bus.kernel_mode = 1'b1; tick();
    do_write(3, 32'h0);
    tick();
    bus.kernel_mode = 1'b0; tick();
    check("prio_id1", 32'(bus.irq_id), 32'd1);
    rd_check("prio_pend", 0);
    check("prio_pend_const", read_exp(0), 32'h2);
    bus.kernel_mode = 1'b1; tick();
    do_write(3, 32'h0);
    bus.kernel_mode = 1'b0; tick();

    // W1C withdraws a request that was not yet taken.
    bus.irq_src = 2'b01; tick();
    bus.irq_src = 2'b00; tick();
    do_write(0, 32'h1);
    tick();
    check("w1c_irq_out", 32'(bus.irq_out), 32'd0);
    rd_check("w1c_pend", 0);

    // New edge coinciding with EOI: set wins.
    bus.irq_src = 2'b01; tick();
    bus.irq_src = 2'b00; tick();
    bus.kernel_mode = 1'b1; tick();
    bus.irq_src = 2'b01;
    do_write(3, 32'h0);
    bus.irq_src = 2'b00;
    rd_check("eoi_edge_pend", 0);
    check("eoi_edge_pend_const", read_exp(0), 32'h1);
    bus.kernel_mode = 1'b0; tick();
    check("eoi_edge_rereq", 32'(bus.irq_out), 32'd1);

    // Asynchronous reset mid-cycle while requesting.
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_irq_out", 32'(bus.irq_out), 32'd0);
    rd_check("async_pend", 0);
    rd_check("async_mask", 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      int unsigned a, r;
      bus.irq_src = NUM_SRC'($urandom_range(0, SRC_ALL));
      if ($urandom_range(0, 3) == 0) bus.kernel_mode = ~bus.kernel_mode;
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 3);
      bus.addr  = 4'(a << 2);
      bus.wdata = (a == 1 && $urandom_range(0, 3) != 0) ? 32'h3 : $urandom;
      bus.wr    = (r < 2);
      bus.rd    = 1'b1;
      #1;
      check("rand_rdata", bus.rdata, read_exp(a));
      bus.rd = 1'b0;
      #1;
      check("rand_rdata_rd0", bus.rdata, 32'd0);
      tick();
      bus.wr = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
